// File: rtl/rx_cmd_pkg.sv
// rx_cmd_pkg: shared definitions for the UART command controller.
//   - CMD_RF_WR / CMD_RF_RD : opcode bytes recognised in IDLE
//   - state_e               : controller state encoding (also exported on the
//                             controller's debug port)
//   - addr_legal()          : address-byte check (bits above the address
//                             field must be zero)
package rx_cmd_pkg;

  localparam logic [7:0] CMD_RF_WR = 8'hAA;
  localparam logic [7:0] CMD_RF_RD = 8'hBB;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_TX_SEND = 3'd5
  } state_e;

  // An address byte is legal when every bit above the address field is zero.
  function automatic logic addr_legal(input logic [7:0] b, input int aw);
    return (b >> aw) == 8'd0;
  endfunction

endpackage

// File: rtl/rx_cmd_timer.sv
// rx_cmd_timer: inactivity timer for the command controller.
// Ports:
//   clk_i     system clock
//   rst_i     synchronous active-high reset
//   clear_i   restart the count from zero (dominates enable_i)
//   enable_i  count one cycle
//   expire_o  high in the cycle where the TIMEOUT_CYCLES-th counted cycle
//             ends; the owner is expected to react and clear the timer
module rx_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  // Combinational from the registered count so the owner can act on the
  // same edge that would complete the TIMEOUT_CYCLES-th cycle.
  assign expire_o = enable_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && !expire_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/rx_cmd_ctrl.sv
// rx_cmd_ctrl: turns the UART RX byte stream into register-file commands.
//   0xAA addr data -> one RF_WR_EN strobe
//   0xBB addr      -> one RF_RD_EN strobe, wait for RF_RD_DATA_VLD, then
//                     offer the read data to the UART TX once TX_BUSY is low
// Malformed bytes (unknown opcode, address with upper bits set, bytes that
// arrive while a read is in flight) produce a one-cycle CMD_ERR.
//
// Optional feature: define RX_CMD_TIMEOUT_EN to abort a command that stalls
// for TIMEOUT_CYCLES in WR_ADDR, WR_DATA, RD_ADDR or RD_WAIT (CMD_ERR, back
// to IDLE). Without it the controller waits indefinitely.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   RX_P_DATA/RX_D_VLD received byte and its one-cycle valid
//   RF_RD_DATA/_VLD   register-file read data and its one-cycle valid
//   TX_BUSY           transmitter busy, no byte is offered while high
//   RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN   register-file bus
//   TX_P_DATA, TX_D_VLD                       byte offered to UART TX
//   CMD_ERR           one-cycle pulse per protocol error
//   state_dbg_o       current controller state (rx_cmd_pkg::state_e)
//
// Handshake: every *_VLD / *_EN / CMD_ERR signal is a single-cycle pulse with
// no back-pressure; a byte is consumed in the cycle its valid is high. The
// only flow control is TX_BUSY, which holds the controller in TX_SEND.
// All outputs are registered and reset to zero.
module rx_cmd_ctrl
  import rx_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [7:0]            RF_RD_DATA,
  input  logic                  RF_RD_DATA_VLD,
  input  logic                  TX_BUSY,
  output logic [ADDR_WIDTH-1:0] RF_ADDR,
  output logic                  RF_WR_EN,
  output logic [7:0]            RF_WR_DATA,
  output logic                  RF_RD_EN,
  output logic [7:0]            TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  CMD_ERR,
  output logic [STATE_W-1:0]    state_dbg_o
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] rf_addr_q;
  logic [7:0]            rf_wr_data_q;
  logic [7:0]            tx_data_q;
  logic                  wr_en_q;
  logic                  rd_en_q;
  logic                  tx_vld_q;
  logic                  err_q;

  logic addr_ok;
  logic timeout;

  assign addr_ok = addr_legal(RX_P_DATA, ADDR_WIDTH);

`ifdef RX_CMD_TIMEOUT_EN
  logic tmr_clear;
  logic tmr_expire;

  // Count only in the four stall-able states. Any consumed byte restarts the
  // count; a byte dropped in RD_WAIT does not, so a chattering line cannot
  // keep a dead read alive. Clearing while in IDLE means every non-IDLE
  // state is entered with a zero count.
  assign tmr_clear = (state_q == ST_IDLE) || (state_q == ST_TX_SEND) ||
                     (RX_D_VLD && (state_q != ST_RD_WAIT));

  rx_cmd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clear_i (tmr_clear),
    .enable_i(!tmr_clear),
    .expire_o(tmr_expire)
  );

  assign timeout = tmr_expire;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      tx_data_q    <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      tx_vld_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      tx_vld_q <= 1'b0;
      err_q    <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == CMD_RF_WR) begin
              state_q <= ST_WR_ADDR;
            end else if (RX_P_DATA == CMD_RF_RD) begin
              state_q <= ST_RD_ADDR;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        ST_WR_ADDR: begin
          if (RX_D_VLD) begin
            if (addr_ok) begin
              rf_addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
              state_q   <= ST_WR_DATA;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else if (timeout) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end

        ST_WR_DATA: begin
          if (RX_D_VLD) begin
            rf_wr_data_q <= RX_P_DATA;
            wr_en_q      <= 1'b1;
            state_q      <= ST_IDLE;
          end else if (timeout) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end

        ST_RD_ADDR: begin
          if (RX_D_VLD) begin
            if (addr_ok) begin
              rf_addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
              rd_en_q   <= 1'b1;
              state_q   <= ST_RD_WAIT;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else if (timeout) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end

        ST_RD_WAIT: begin
          // A byte here is dropped; read data arriving in the same cycle is
          // still captured. Read data beats a coincident timeout.
          if (RX_D_VLD) begin
            err_q <= 1'b1;
          end
          if (RF_RD_DATA_VLD) begin
            tx_data_q <= RF_RD_DATA;
            state_q   <= ST_TX_SEND;
          end else if (timeout) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end

        ST_TX_SEND: begin
          if (RX_D_VLD) begin
            err_q <= 1'b1;
          end
          if (!TX_BUSY) begin
            tx_vld_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign RF_ADDR     = rf_addr_q;
  assign RF_WR_EN    = wr_en_q;
  assign RF_WR_DATA  = rf_wr_data_q;
  assign RF_RD_EN    = rd_en_q;
  assign TX_P_DATA   = tx_data_q;
  assign TX_D_VLD    = tx_vld_q;
  assign CMD_ERR     = err_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// tb_rx_cmd_ctrl: self-checking bench for rx_cmd_ctrl.
// The driver feeds bytes and a byte-level command model predicts register
// writes, read strobes, transmitted bytes and errors into expected queues;
// a monitor on the falling edge pops and compares whenever a strobe appears.
// A register-file responder answers each read after a programmable delay.
module tb_rx_cmd_ctrl;
  import rx_cmd_pkg::*;

  localparam int AW  = 4;
  localparam int TMO = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic [7:0]    RX_P_DATA;
  logic          RX_D_VLD;
  logic [7:0]    RF_RD_DATA;
  logic          RF_RD_DATA_VLD;
  logic          TX_BUSY;
  logic [AW-1:0] RF_ADDR;
  logic          RF_WR_EN;
  logic [7:0]    RF_WR_DATA;
  logic          RF_RD_EN;
  logic [7:0]    TX_P_DATA;
  logic          TX_D_VLD;
  logic          CMD_ERR;
  logic [STATE_W-1:0] state_dbg;

  rx_cmd_ctrl #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .RX_P_DATA     (RX_P_DATA),
    .RX_D_VLD      (RX_D_VLD),
    .RF_RD_DATA    (RF_RD_DATA),
    .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
    .TX_BUSY       (TX_BUSY),
    .RF_ADDR       (RF_ADDR),
    .RF_WR_EN      (RF_WR_EN),
    .RF_WR_DATA    (RF_WR_DATA),
    .RF_RD_EN      (RF_RD_EN),
    .TX_P_DATA     (TX_P_DATA),
    .TX_D_VLD      (TX_D_VLD),
    .CMD_ERR       (CMD_ERR),
    .state_dbg_o   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [11:0] exp_wr_q[$];   // {addr, data}
  logic [3:0]  exp_rd_q[$];   // addr
  logic [7:0]  exp_tx_q[$];   // read-back byte
  logic [7:0]  exp_err_q[$];  // offending byte (informational)
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Byte-level command model: bytes of the command gathered so far, plus
  // whether a read is still waiting for its TX byte to leave.
  logic [7:0] cmd_q[$];
  bit         read_pending = 1'b0;

  int         rf_delay = 2;
  bit         rf_fixed = 1'b0;
  logic [7:0] rf_fixed_data = 8'h00;
  logic [7:0] rf_d;
  bit         spur_req = 1'b0;
  int         rf_vld_cyc = 0;
  int         tx_cyc = 0;
  int         err_cyc = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (read_pending) begin
      exp_err_q.push_back(b);
    end else if (cmd_q.size() == 0) begin
      if (b == 8'hAA || b == 8'hBB) cmd_q.push_back(b);
      else exp_err_q.push_back(b);
    end else if (cmd_q.size() == 1) begin
      if (int'(b) >= (1 << AW)) begin
        exp_err_q.push_back(b);
        cmd_q.delete();
      end else if (cmd_q[0] == 8'hAA) begin
        cmd_q.push_back(b);
      end else begin
        exp_rd_q.push_back(b[3:0]);
        read_pending = 1'b1;
        cmd_q.delete();
      end
    end else begin
      exp_wr_q.push_back({cmd_q[1][3:0], b});
      cmd_q.delete();
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (mon_en && !RST) begin
      if (RF_WR_EN) begin
        if (exp_wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected actual=addr %0h data %0h required=no write", RF_ADDR, RF_WR_DATA);
        end else begin
          check("wr_cmd", {20'd0, RF_ADDR, RF_WR_DATA}, {20'd0, exp_wr_q.pop_front()});
        end
      end
      if (RF_RD_EN) begin
        if (exp_rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected actual=addr %0h required=no read", RF_ADDR);
        end else begin
          check("rd_addr", {28'd0, RF_ADDR}, {28'd0, exp_rd_q.pop_front()});
        end
      end
      if (TX_D_VLD) begin
        tx_cyc = cyc;
        if (exp_tx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected actual=%0h required=no tx", TX_P_DATA);
        end else begin
          check("tx_data", {24'd0, TX_P_DATA}, {24'd0, exp_tx_q.pop_front()});
          check("tx_turnaround", {31'd0, tx_cyc > rf_vld_cyc}, 32'd1);
        end
        read_pending = 1'b0;
      end
      if (CMD_ERR) begin
        err_cyc = cyc;
        if (exp_err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL err_unexpected actual=CMD_ERR required=no error");
        end else begin
          checks++;
          void'(exp_err_q.pop_front());
        end
      end
    end
  end

  // ---------------- register-file responder ----------------
  initial begin
    RF_RD_DATA     = 8'h00;
    RF_RD_DATA_VLD = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST && RF_RD_EN) begin
        rf_d = rf_fixed ? rf_fixed_data : 8'($urandom);
        repeat (rf_delay) @(posedge CLK);
        #1;
        RF_RD_DATA     = rf_d;
        RF_RD_DATA_VLD = 1'b1;
        exp_tx_q.push_back(rf_d);
        rf_vld_cyc     = cyc;
        @(posedge CLK);
        #1;
        RF_RD_DATA_VLD = 1'b0;
      end else if (spur_req) begin
        @(posedge CLK);
        #1;
        RF_RD_DATA     = 8'h5A;
        RF_RD_DATA_VLD = 1'b1;
        @(posedge CLK);
        #1;
        RF_RD_DATA_VLD = 1'b0;
        spur_req       = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    model_byte(b);
    tick(1);
    RX_D_VLD  = 1'b0;
  endtask

  // Let outstanding reads finish and all expected strobes drain (bounded).
  task automatic wait_quiet(input string name, input bit busy_rand);
    int k = 0;
    while ((read_pending || exp_wr_q.size() != 0 || exp_rd_q.size() != 0 ||
            exp_tx_q.size() != 0 || exp_err_q.size() != 0) && k < 300) begin
      if (busy_rand) TX_BUSY = ($urandom_range(0, 3) == 0);
      tick(1);
      k++;
    end
    tick(2);
    check({"settle_", name}, {31'd0, k >= 300}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int t0;
  int busy_fall;
  int r;

  initial begin
    RST       = 1'b1;
    RX_P_DATA = 8'h00;
    RX_D_VLD  = 1'b0;
    TX_BUSY   = 1'b0;
    tick(3);
    check("reset_outputs",
          {8'd0, RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, TX_P_DATA, TX_D_VLD, CMD_ERR},
          32'd0);
    check("reset_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    RST    = 1'b0;
    mon_en = 1'b1;
    tick(1);

    // basic write
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h5C);
    wait_quiet("write", 1'b0);
    check("wr_hold", {20'd0, RF_ADDR, RF_WR_DATA}, 32'h35C);

    // basic read, RF answers 3 cycles after RF_RD_EN
    rf_fixed = 1'b1; rf_fixed_data = 8'h9E; rf_delay = 3;
    send_byte(8'hBB); send_byte(8'h07);
    wait_quiet("read", 1'b0);
    check("tx_hold", {24'd0, TX_P_DATA}, 32'h9E);

    // unknown opcode, then a normal write
    send_byte(8'h42);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h11);
    wait_quiet("bad_opcode", 1'b0);

    // illegal write address
    send_byte(8'hAA); send_byte(8'h1F);
    wait_quiet("bad_addr", 1'b0);

    // read held by TX_BUSY for 20 cycles; a byte dropped while waiting
    rf_fixed = 1'b0; rf_delay = 2;
    TX_BUSY = 1'b1;
    send_byte(8'hBB); send_byte(8'h02);
    tick(8);
    send_byte(8'h66);
    tick(11);
    TX_BUSY   = 1'b0;
    busy_fall = cyc;
    wait_quiet("busy_read", 1'b0);
    check("busy_release", tx_cyc, busy_fall + 1);

    // byte in RD_WAIT, then byte coincident with read data
    rf_fixed = 1'b1; rf_fixed_data = 8'h77; rf_delay = 3;
    send_byte(8'hBB); send_byte(8'h05);
    tick(1);
    send_byte(8'h12);
    tick(1);
    send_byte(8'h34);
    wait_quiet("rd_wait_drop", 1'b0);
    check("coincident_capture", {24'd0, TX_P_DATA}, 32'h77);

    // stray read data in IDLE is ignored
    spur_req = 1'b1;
    tick(4);
    send_byte(8'hAA); send_byte(8'h04); send_byte(8'hC3);
    wait_quiet("stray_rd_vld", 1'b0);

    // reset mid-command, with a data byte arriving under reset
    send_byte(8'hAA); send_byte(8'h02);
    RX_P_DATA = 8'h44; RX_D_VLD = 1'b1; RST = 1'b1;
    cmd_q.delete();
    tick(1);
    RX_D_VLD = 1'b0; RST = 1'b0;
    check("rst_mid_outputs",
          {8'd0, RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, TX_P_DATA, TX_D_VLD, CMD_ERR},
          32'd0);
    send_byte(8'h33);
    wait_quiet("rst_mid", 1'b0);

`ifdef RX_CMD_TIMEOUT_EN
    // opcode then silence
    send_byte(8'hAA);
    t0 = cyc;
    exp_err_q.push_back(8'h00);
    cmd_q.delete();
    wait_quiet("timeout", 1'b0);
    check("timeout_cycles", err_cyc - t0, 32'(TMO));
`endif

    // randomized command stream
    rf_fixed = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (read_pending) wait_quiet("rand_read", 1'b1);
      rf_delay = $urandom_range(1, 5);
      TX_BUSY  = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      if (r <= 2)      send_byte(8'hAA);
      else if (r <= 4) send_byte(8'hBB);
      else if (r <= 7) send_byte(8'($urandom_range(0, 15)));
      else if (r == 8) send_byte(8'($urandom_range(16, 255)));
      else             send_byte(8'($urandom));
      tick($urandom_range(0, 2));
    end
    while (cmd_q.size() != 0) send_byte(8'h01);
    wait_quiet("rand_end", 1'b1);
    TX_BUSY = 1'b0;
    tick(4);

    check("queues_empty",
          exp_wr_q.size() + exp_rd_q.size() + exp_tx_q.size() + exp_err_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
